mac_seq: RTL
============

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter: W, default 16, operand/accumulator width.
REQ-002 Parameter: LEN_W, default 8, width of term-count input.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  begin a dot product; sampled only in IDLE.
REQ-006 Port: length  input  LEN_W  number of terms; captured when start accepted; 0 legal.
REQ-007 Port: op_valid  input  1  operand pair present.
REQ-008 Port: op_ready  output  1  block accepts operand pair.
REQ-009 Port: op_a, op_b  input  W each  operands; unsigned.
REQ-010 Port: res_valid  output  1  result present.
REQ-011 Port: res_ready  input  1  consumer accepts result.
REQ-012 Port: res_data  output  W  accumulated result.
REQ-013 Port: ovf  output  1  overflow flag for current/last result.
REQ-014 Port: busy  output  1  high in any state other than IDLE.
REQ-015 Port: idx  output  LEN_W  number of terms accepted in current operation.

Function
REQ-016 FSM states: IDLE, CLEAR, ACCUM, RESULT; no other reachable states.
REQ-017 IDLE: start=1 -> capture length, go to CLEAR; start=0 -> stay; op_ready=0, res_valid=0.
REQ-018 CLEAR (one cycle): acc<=0, idx<=0, ovf<=0; captured length=0 -> RESULT, else -> ACCUM.
REQ-019 ACCUM: op_ready=1; transfer = op_valid & op_ready on a rising edge.
REQ-020 Per transfer: acc <= (acc + low W bits of op_a*op_b) mod 2^W; idx <= idx+1.
REQ-021 ovf sets (sticky until next CLEAR) if the full 2W-bit product exceeds 2^W-1 or the addition carries out.
REQ-022 Transfer with idx = length-1 -> RESULT on same edge; op_ready low in the following cycle.
REQ-023 op_valid low in ACCUM: no state change; gaps of any length are legal.
REQ-024 RESULT: res_valid=1, res_data=acc, ovf stable; held unchanged until res_ready=1, then -> IDLE.
REQ-025 Latency: start at edge t -> op_ready high in cycle after edge t+1; last transfer at edge e -> res_valid high after edge e.
REQ-026 start outside IDLE is ignored; length changes outside IDLE have no effect.
REQ-027 res_data = 0 whenever not in RESULT.
REQ-028 idx wraps never: length <= 2^LEN_W-1 bounds idx.

Reset
REQ-029 reset=1 asynchronously forces IDLE, acc=0, idx=0, ovf=0, captured length=0.
REQ-030 Reset values: op_ready=0, res_valid=0, res_data=0, busy=0, ovf=0, idx=0.
REQ-031 Reset mid-operation discards partial accumulation; no result is emitted.

Structure
REQ-032 Shared package mm_pkg holds the state encoding (2-bit: IDLE=0, CLEAR=1, ACCUM=2, RESULT=3) and default W/LEN_W constants.
REQ-033 One sub-module, mac_unit: combinational multiply-add of acc, op_a, op_b producing next acc and overflow bit; FSM, counter and handshake stay in mac_seq.
REQ-034 All outputs driven from registers or decoded directly from the state register; no combinational path from op_valid to op_ready or from res_ready to res_valid.

Verification
REQ-035 Reset, start with length=3, operands (2,3),(4,5),(1,1) back-to-back -> res_data=27, ovf=0, idx=3, res_valid one cycle after third transfer.
REQ-036 start with length=0 -> no op_ready pulse; res_valid=1 two edges after start, res_data=0, ovf=0.
REQ-037 length=1, operands (16'h0100,16'h0100) -> res_data=0, ovf=1; next operation with (1,1) -> ovf=0, res_data=1.
REQ-038 res_ready held low 5 cycles in RESULT, start pulsed meanwhile -> res_valid, res_data stable, start ignored, busy=1; res_ready=1 -> IDLE next edge.
REQ-039 length=3, reset asserted between edges after first transfer -> all outputs to reset values immediately; fresh start with length=2, (3,3),(1,2) -> res_data=11.
REQ-040 length=2 with op_valid low 3 cycles between operands (7,2),(1,6) -> res_data=20, idx increments only on transfers.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared definitions for the sequential multiply-accumulate block.
package mm_pkg;

    // Default operand/accumulator width and term-count width.
    localparam int unsigned DefW    = 16;
    localparam int unsigned DefLenW = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StClear  = 2'd1,
        StAccum  = 2'd2,
        StResult = 2'd3
    } state_e;

endpackage

// File: rtl/mac_unit.sv
// Combinational multiply-add: next accumulator value plus an overflow bit that is set
// when the full product does not fit in W bits or the addition carries out.
module mac_unit
    import mm_pkg::*;
#(
    parameter int unsigned W = DefW
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [W-1:0] acc_next,
    output logic         ovf
);

    logic [2*W-1:0] prod;
    logic [W:0]     sum;

    // Full-width product, then add the low half with a carry bit.
    always_comb begin
        prod     = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
        sum      = {1'b0, acc} + {1'b0, prod[W-1:0]};
        acc_next = sum[W-1:0];
        ovf      = (|prod[2*W-1:W]) | sum[W];
    end

endmodule

// File: rtl/mac_seq.sv
// Sequential dot-product engine: accepts 'length' operand pairs over a valid/ready
// handshake, accumulates their products modulo 2^W and presents the result until taken.
module mac_seq
    import mm_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned LEN_W = DefLenW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [W-1:0]     res_data,
    output logic             ovf,
    output logic             busy,
    output logic [LEN_W-1:0] idx
);

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;

    logic [W-1:0]     mac_acc_next;
    logic             mac_ovf;

    mac_unit #(
        .W (W)
    ) u_mac_unit (
        .acc      (acc_q),
        .op_a     (op_a),
        .op_b     (op_b),
        .acc_next (mac_acc_next),
        .ovf      (mac_ovf)
    );

    // Next-state logic for the controller and the datapath registers.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    len_d   = length;
                    state_d = StClear;
                end
            end
            StClear: begin
                acc_d   = '0;
                idx_d   = '0;
                ovf_d   = 1'b0;
                state_d = (len_q == '0) ? StResult : StAccum;
            end
            StAccum: begin
                // op_ready is high throughout this state, so op_valid alone marks a transfer.
                if (op_valid) begin
                    acc_d = mac_acc_next;
                    idx_d = idx_q + LEN_W'(1);
                    ovf_d = ovf_q | mac_ovf;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = StResult;
                    end
                end
            end
            StResult: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
        end
    end

    // Outputs decoded only from registered state.
    always_comb begin
        op_ready  = (state_q == StAccum);
        res_valid = (state_q == StResult);
        res_data  = (state_q == StResult) ? acc_q : '0;
        busy      = (state_q != StIdle);
        ovf       = ovf_q;
        idx       = idx_q;
    end

endmodule
